por_seq_checker: RTL and testbench

- Parametrised power-on-reset sequence checker for the user project area.
- Takes NUM_CH raw power-good flags from analog POR instances, then synchronises and debounces each one.
- Checks that the channels come up in ascending index order and detects brown-out.
- Reports per-stage check codes and debounced status on GPIO-facing outputs. This generalises the fixed two-POR status/checkbit handshake to N channels, with fault reporting and a clear/restart mode.

---
 rtl/por_seq_pkg.sv | 28 ++
 rtl/por_seq_checker_debounce.sv | 39 +++
 rtl/por_seq_checker.sv | 153 +++++++++++++++
 tb/tb_por_seq_checker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/por_seq_pkg.sv
// Shared types, default codes and helpers for the POR sequence checker.
package por_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOW = 3'd0,
      IDLE     = 3'd1,
      RAMP     = 3'd2,
      ALL_UP   = 3'd3,
      FAULT    = 3'd4
   } state_t;

   localparam int          MAX_CH          = 8;
   localparam logic [3:0]  DEF_CODE_ORDER  = 4'hE;
   localparam logic [3:0]  DEF_CODE_BROWN  = 4'hD;
   localparam logic [15:0] DEF_STAGE_CODES = 16'hF359;

   // Length of the contiguous run of ones starting at bit 0.
   function automatic logic [3:0] prefix_ones(input logic [MAX_CH-1:0] v);
      logic run;
      prefix_ones = 4'd0;
      run = 1'b1;
      for (int i = 0; i < MAX_CH; i++) begin
         if (run && v[i]) prefix_ones = prefix_ones + 4'd1;
         else             run = 1'b0;
      end
   endfunction

endpackage

// File: rtl/por_seq_checker_debounce.sv
// One POR channel: 2-flop synchroniser followed by a stable-count debouncer.
module por_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clock,
   input  logic resetb,
   input  logic raw,
   output logic good
);
   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          s1_q, s2_q, good_q;
   logic [CW-1:0] cnt_q;

   // Sync the raw flag, then flip good only after DEB_CYCLES disagreeing cycles.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         good_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         if (s2_q == good_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            // this is the DEB_CYCLES-th disagreeing cycle
            good_q <= ~good_q;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign good = good_q;

endmodule

// File: rtl/por_seq_checker.sv
// N-channel power-on-reset sequence checker: debounced status, in-order
// ramp tracking, order / brown-out fault detection and a clear/restart path.
module por_seq_checker
   import por_seq_pkg::*;
#(
   parameter int                         NUM_CH      = 4,
   parameter int                         DEB_CYCLES  = 16,
   parameter int                         CODE_W      = 4,
   parameter logic [NUM_CH*CODE_W-1:0]   STAGE_CODES = (NUM_CH*CODE_W)'(DEF_STAGE_CODES),
   parameter logic [CODE_W-1:0]          CODE_ORDER  = CODE_W'(DEF_CODE_ORDER),
   parameter logic [CODE_W-1:0]          CODE_BROWN  = CODE_W'(DEF_CODE_BROWN),
   parameter bit                         STRICT      = 1'b1
) (
   input  logic                          clock,
   input  logic                          resetb,
   input  logic [NUM_CH-1:0]             por_raw,
   input  logic                          brown_en,
   input  logic                          clear,
   output logic [NUM_CH-1:0]             status,
   output logic [CODE_W-1:0]             checkbits,
   output logic [$clog2(NUM_CH+1)-1:0]   stage,
   output logic                          fault,
   output logic                          irq
);
   localparam int SW = $clog2(NUM_CH + 1);

   logic [NUM_CH-1:0] good, good_prev_q, rise, below, onehot, above_p;
   logic [SW-1:0]     p, stage_q, stage_d;
   logic [CODE_W-1:0] code_q, code_d;
   state_t            state_q, state_d;
   logic              fault_q, irq_q, irq_d, pend_q, pend_d;
   logic              fell, brown, ord, entry, fire;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      por_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clock (clock),
         .resetb(resetb),
         .raw   (por_raw[i]),
         .good  (good[i])
      );
   end

   function automatic logic [CODE_W-1:0] code_of(input logic [SW-1:0] s);
      code_of = '0;
      for (int k = 1; k <= NUM_CH; k++)
         if (s == SW'(k)) code_of = STAGE_CODES[k*CODE_W-1 -: CODE_W];
   endfunction

   // Next-state / output decode. Order faults look at newly risen bits, so
   // channels left high after a tolerated (brown_en=0) drop are not flagged
   // again; they rejoin the prefix once the missing channel returns.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      code_d  = code_q;
      entry   = 1'b0;
      p       = SW'(prefix_ones(MAX_CH'(good)));
      rise    = good & ~good_prev_q;
      for (int i = 0; i < NUM_CH; i++) begin
         below[i]   = (SW'(i) <  stage_q);
         onehot[i]  = (SW'(i) == stage_q);
         above_p[i] = (SW'(i) >= p);
      end
      fell  = ((good & below) != below);
      brown = brown_en && fell;
      if (STRICT) ord = ((rise & ~below) != '0) && (rise != onehot);
      else        ord = ((rise & above_p) != '0);

      case (state_q)
         WAIT_LOW: begin
            stage_d = '0;
            code_d  = '0;
            if (good == '0) state_d = IDLE;
         end
         IDLE, RAMP: begin
            if (brown) begin
               state_d = FAULT;
               code_d  = CODE_BROWN;
               entry   = 1'b1;
            end else if (ord) begin
               state_d = FAULT;
               code_d  = CODE_ORDER;
               entry   = 1'b1;
            end else begin
               stage_d = p;
               code_d  = code_of(p);
               if (p == SW'(NUM_CH)) begin
                  state_d = ALL_UP;
                  entry   = 1'b1;
               end else begin
                  state_d = (p == '0) ? IDLE : RAMP;
               end
            end
         end
         ALL_UP: begin
            if (brown) begin
               state_d = FAULT;
               code_d  = CODE_BROWN;
               entry   = 1'b1;
            end else if (clear) begin
               state_d = WAIT_LOW;
               stage_d = '0;
               code_d  = '0;
            end else if (fell) begin
               stage_d = p;
               code_d  = code_of(p);
               state_d = (p == '0) ? IDLE : RAMP;
            end
         end
         FAULT: begin
            if (clear) begin
               state_d = WAIT_LOW;
               stage_d = '0;
               code_d  = '0;
            end
         end
         default: state_d = WAIT_LOW;
      endcase

      // Back-to-back entries (ALL_UP then FAULT) defer the second pulse a cycle.
      fire   = entry || pend_q;
      irq_d  = fire && !irq_q;
      pend_d = fire && irq_q;
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (!resetb) begin
         state_q     <= IDLE;
         stage_q     <= '0;
         code_q      <= '0;
         fault_q     <= 1'b0;
         irq_q       <= 1'b0;
         pend_q      <= 1'b0;
         good_prev_q <= '0;
      end else begin
         state_q     <= state_d;
         stage_q     <= stage_d;
         code_q      <= code_d;
         fault_q     <= (state_d == FAULT);
         irq_q       <= irq_d;
         pend_q      <= pend_d;
         good_prev_q <= good;
      end
   end

   assign status    = good;
   assign checkbits = code_q;
   assign stage     = stage_q;
   assign fault     = fault_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_por_seq_checker.sv
// Directed bench for por_seq_checker with an event scoreboard on
// {checkbits, stage, fault, irq}; a STRICT=0 twin shares the stimulus.
module tb_por_seq_checker;
   logic       clock = 1'b0;
   logic       resetb, brown_en, clear;
   logic [3:0] por_raw;
   logic [3:0] status, checkbits, status0, checkbits0;
   logic [2:0] stage, stage0;
   logic       fault, irq, fault0, irq0;

   int checks = 0, failures = 0, cyc = 0, evt_cyc = 0, irq_cnt = 0, t0 = 0;
   bit mon_en = 1'b0;

   typedef struct packed {
      logic [3:0] code;
      logic [2:0] stg;
      logic       flt;
      logic       irq;
   } exp_t;
   exp_t  exp_q[$];
   string tag_q[$];

   por_seq_checker dut (
      .clock(clock), .resetb(resetb), .por_raw(por_raw), .brown_en(brown_en),
      .clear(clear), .status(status), .checkbits(checkbits), .stage(stage),
      .fault(fault), .irq(irq));

   por_seq_checker #(.STRICT(1'b0)) dut0 (
      .clock(clock), .resetb(resetb), .por_raw(por_raw), .brown_en(brown_en),
      .clear(clear), .status(status0), .checkbits(checkbits0), .stage(stage0),
      .fault(fault0), .irq(irq0));

   always #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [3:0] c, input logic [2:0] s,
                       input logic f, input logic i);
      exp_t e;
      e.code = c; e.stg = s; e.flt = f; e.irq = i;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      assert (exp_q.size() == 0) else begin
         failures++;
         $error("FAIL %s_timeout observed=%0d_pending expected=0", tag, exp_q.size());
         exp_q.delete();
         tag_q.delete();
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Scoreboard monitor: every change of {checkbits,stage,fault} pops one entry.
   initial begin
      logic [7:0] prev_sig;
      logic       irq_prev;
      exp_t       e;
      prev_sig = '0;
      irq_prev = 1'b0;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if ({checkbits, stage, fault} !== prev_sig) begin
               prev_sig = {checkbits, stage, fault};
               evt_cyc  = cyc;
               checks++;
               assert (exp_q.size() != 0) else begin
                  failures++;
                  $error("FAIL unexpected_event observed=%0h expected=none", prev_sig);
               end
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk(tag_q.pop_front(), 32'({checkbits, stage, fault, irq}), 32'(e));
               end
            end
            if (irq) begin
               irq_cnt++;
               checks++;
               assert (!irq_prev) else begin
                  failures++;
                  $error("FAIL irq_consecutive observed=1 expected=0");
               end
            end
            irq_prev = irq;
         end
      end
   end

   initial begin
      logic [3:0] codes [4];
      codes[0] = 4'h9; codes[1] = 4'h5; codes[2] = 4'h3; codes[3] = 4'hF;

      resetb = 1'b0; por_raw = '0; brown_en = 1'b1; clear = 1'b0;
      repeat (3) tick();
      chk("rst_status",    32'(status),    0);
      chk("rst_checkbits", 32'(checkbits), 0);
      chk("rst_stage",     32'(stage),     0);
      chk("rst_fault",     32'(fault),     0);
      chk("rst_irq",       32'(irq),       0);
      chk("rst_status0",   32'(status0),   0);
      resetb = 1'b1;
      mon_en = 1'b1;

      // glitch shorter than the debounce window
      por_raw[0] = 1'b1;
      repeat (10) tick();
      por_raw[0] = 1'b0;
      repeat (30) tick();
      chk("glitch_status",    32'(status),    0);
      chk("glitch_checkbits", 32'(checkbits), 0);
      chk("glitch_irq",       32'(irq_cnt),   0);

      // clear in IDLE does nothing (any output change would be unexpected)
      pulse_clear();
      repeat (3) tick();

      // in-order power-up with latency checks on the first channel
      push("up_s1", 4'h9, 3'd1, 1'b0, 1'b0);
      t0 = cyc;
      por_raw[0] = 1'b1;
      repeat (17) tick();
      chk("lat_status_pre", 32'(status), 0);
      tick();
      chk("lat_status", 32'(status), 4'b0001);
      drain("up_s1", 10);
      chk("lat_stage", 32'(evt_cyc - t0), 19);
      repeat (180) tick();
      push("up_s2", 4'h5, 3'd2, 1'b0, 1'b0);
      por_raw[1] = 1'b1;
      drain("up_s2", 30);
      chk("up_status2", 32'(status), 4'b0011);
      push("up_s3", 4'h3, 3'd3, 1'b0, 1'b0);
      por_raw[2] = 1'b1;
      drain("up_s3", 30);
      push("up_all", 4'hF, 3'd4, 1'b0, 1'b1);
      por_raw[3] = 1'b1;
      drain("up_all", 30);
      repeat (5) tick();
      chk("up_irq_cnt", 32'(irq_cnt), 1);
      chk("up_status4", 32'(status), 4'b1111);

      // brown-out with detection enabled
      irq_cnt = 0;
      push("brown", 4'hD, 3'd4, 1'b1, 1'b1);
      por_raw[1] = 1'b0;
      drain("brown", 30);
      por_raw = '0;
      repeat (25) tick();
      chk("brown_hold_code",  32'(checkbits), 4'hD);
      chk("brown_hold_stage", 32'(stage),     4);
      chk("brown_irq_cnt",    32'(irq_cnt),   1);
      push("brown_clr", 4'h0, 3'd0, 1'b0, 1'b0);
      pulse_clear();
      drain("brown_clr", 5);
      repeat (3) tick();

      // order fault: channel 2 first
      push("order", 4'hE, 3'd0, 1'b1, 1'b1);
      por_raw[2] = 1'b1;
      drain("order", 30);
      chk("order_fault0", 32'(fault0), 1);
      por_raw = '0;
      repeat (25) tick();
      push("order_clr", 4'h0, 3'd0, 1'b0, 1'b0);
      pulse_clear();
      drain("order_clr", 5);
      repeat (3) tick();

      // normal sequence again, brown-out detection off
      brown_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push("reseq", codes[i], 3'(i + 1), 1'b0, (i == 3));
         por_raw[i] = 1'b1;
         drain("reseq", 30);
      end
      push("brownoff", 4'h9, 3'd1, 1'b0, 1'b0);
      por_raw[1] = 1'b0;
      drain("brownoff", 30);
      repeat (30) tick();
      chk("brownoff_fault",  32'(fault),  0);
      chk("brownoff_status", 32'(status), 4'b1101);
      push("recover", 4'hF, 3'd4, 1'b0, 1'b1);
      por_raw[1] = 1'b1;
      drain("recover", 30);

      // clear from ALL_UP, then ramp to stage 2 and reset mid-sequence
      push("wl", 4'h0, 3'd0, 1'b0, 1'b0);
      pulse_clear();
      drain("wl", 5);
      por_raw = '0;
      repeat (25) tick();
      push("mid_s1", 4'h9, 3'd1, 1'b0, 1'b0);
      por_raw[0] = 1'b1;
      drain("mid_s1", 30);
      push("mid_s2", 4'h5, 3'd2, 1'b0, 1'b0);
      por_raw[1] = 1'b1;
      drain("mid_s2", 30);
      chk("mid_stage0", 32'(stage0), 2);
      push("rst_mid", 4'h0, 3'd0, 1'b0, 1'b0);
      resetb = 1'b0;
      tick();
      resetb = 1'b1;
      t0 = cyc;
      chk("rst_mid_status",  32'(status),     0);
      chk("rst_mid_code0",   32'(checkbits0), 0);
      chk("rst_mid_stage0",  32'(stage0),     0);
      drain("rst_mid", 2);
      // both channels re-debounce together: a simultaneous rise
      push("simul_strict", 4'hE, 3'd0, 1'b1, 1'b1);
      drain("simul_strict", 40);
      chk("rst_relat",     32'(evt_cyc - t0), 19);
      chk("simul_status",  32'(status),     4'b0011);
      chk("simul_stage0",  32'(stage0),     2);
      chk("simul_code0",   32'(checkbits0), 4'h5);
      chk("simul_fault0",  32'(fault0),     0);

      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
